// File: rtl/microfluidic_sequencer_top.sv
// rtl/microfluidic_sequencer_top.sv - programmable valve/pump sequencer with program RAM and four PWM channels
module microfluidic_sequencer_top #(
    parameter int DELAY_SCALE = 1,
    parameter int PWM_BITS    = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  i,
    input  logic [12:0] instruction,
    output logic        PWM_0,
    output logic        PWM_1,
    output logic        PWM_2,
    output logic        PWM_3,
    output logic        demux_out0,
    output logic        demux_out1,
    output logic        demux_out2,
    output logic        demux_out3,
    output logic        delay_start,
    output logic        count_done,
    output logic        rst_flag
);

    localparam int PW = (DELAY_SCALE > 1) ? $clog2(DELAY_SCALE) : 1;

    localparam logic [2:0] OP_SET  = 3'b001;
    localparam logic [2:0] OP_WAIT = 3'b010;
    localparam logic [2:0] OP_HALT = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WAIT,
        S_HALT
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [12:0]         mem [256];
    logic [12:0]         ir;
    logic [7:0]          pc;
    logic [9:0]          cnt;
    logic [PW-1:0]       presc;
    logic [5:0]          duty [4];
    logic [3:0]          demux_q;
    logic [PWM_BITS-1:0] c;
    logic [2:0]          opcode;
    logic                presc_last;
    logic                wait_done;

    assign opcode     = ir[12:10];
    assign presc_last = (presc == PW'(DELAY_SCALE - 1));
    // A zero count finishes on the first WAIT cycle; otherwise finish on the last prescaler slot of the last tick.
    assign wait_done  = (cnt == 10'd0) || ((cnt == 10'd1) && presc_last);

    assign demux_out0 = demux_q[0];
    assign demux_out1 = demux_q[1];
    assign demux_out2 = demux_q[2];
    assign demux_out3 = demux_q[3];
    assign rst_flag   = (state == S_HALT);

    assign PWM_0 = (c < PWM_BITS'(duty[0]));
    assign PWM_1 = (c < PWM_BITS'(duty[1]));
    assign PWM_2 = (c < PWM_BITS'(duty[2]));
    assign PWM_3 = (c < PWM_BITS'(duty[3]));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; start only matters in IDLE and HALT.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_FETCH;
            S_FETCH: next_state = S_EXEC;
            S_EXEC: begin
                case (opcode)
                    OP_WAIT: next_state = S_WAIT;
                    OP_HALT: next_state = S_HALT;
                    default: next_state = S_FETCH;
                endcase
            end
            S_WAIT:  if (wait_done) next_state = S_FETCH;
            S_HALT:  if (!start) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Program RAM: loaded only in IDLE, read synchronously into ir during FETCH; never cleared by reset.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && !start) begin
            mem[i] <= instruction;
        end
        if (state == S_FETCH) begin
            ir <= mem[pc];
        end
    end

    // Datapath: pc, delay counter, duty registers, strobes and the free-running PWM counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= 8'd1;
            cnt         <= 10'd0;
            presc       <= '0;
            demux_q     <= 4'b0;
            delay_start <= 1'b0;
            count_done  <= 1'b0;
            c           <= '0;
            for (int k = 0; k < 4; k++) duty[k] <= 6'd0;
        end else begin
            c           <= c + 1'b1;
            demux_q     <= 4'b0;
            delay_start <= 1'b0;
            count_done  <= 1'b0;
            case (state)
                S_IDLE: pc <= 8'd1;
                S_EXEC: begin
                    case (opcode)
                        OP_SET: begin
                            for (int k = 0; k < 4; k++) begin
                                if (ir[6+k]) duty[k] <= ir[5:0];
                            end
                            demux_q <= ir[9:6];
                            pc      <= pc + 8'd1;
                        end
                        OP_WAIT: begin
                            delay_start <= 1'b1;
                            cnt         <= ir[9:0];
                            presc       <= '0;
                        end
                        OP_HALT: begin
                            for (int k = 0; k < 4; k++) duty[k] <= 6'd0;
                        end
                        default: pc <= pc + 8'd1;
                    endcase
                end
                S_WAIT: begin
                    if (wait_done) begin
                        count_done <= 1'b1;
                        pc         <= pc + 8'd1;
                    end else if (presc_last) begin
                        presc <= '0;
                        cnt   <= cnt - 10'd1;
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                S_HALT: begin
                    for (int k = 0; k < 4; k++) duty[k] <= 6'd0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_microfluidic_sequencer_top.sv
// tb/tb_microfluidic_sequencer_top.sv - directed-vector bench for microfluidic_sequencer_top
module tb_microfluidic_sequencer_top;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  i;
    logic [12:0] instruction;

    logic pwm0, pwm1, pwm2, pwm3, dm0, dm1, dm2, dm3, ds, cd, rf;
    logic q_pwm0, q_pwm1, q_pwm2, q_pwm3, q_dm0, q_dm1, q_dm2, q_dm3, q_ds, q_cd, q_rf;

    int vectors     = 0;
    int miscompares = 0;
    int pcount [4];
    int diff_cycles;
    int n;

    always #5 clk = ~clk;

    microfluidic_sequencer_top #(.DELAY_SCALE(1), .PWM_BITS(6)) dut (
        .clk(clk), .rst(rst), .start(start), .i(i), .instruction(instruction),
        .PWM_0(pwm0), .PWM_1(pwm1), .PWM_2(pwm2), .PWM_3(pwm3),
        .demux_out0(dm0), .demux_out1(dm1), .demux_out2(dm2), .demux_out3(dm3),
        .delay_start(ds), .count_done(cd), .rst_flag(rf)
    );

    microfluidic_sequencer_top #(.DELAY_SCALE(4), .PWM_BITS(6)) dut4 (
        .clk(clk), .rst(rst), .start(start), .i(i), .instruction(instruction),
        .PWM_0(q_pwm0), .PWM_1(q_pwm1), .PWM_2(q_pwm2), .PWM_3(q_pwm3),
        .demux_out0(q_dm0), .demux_out1(q_dm1), .demux_out2(q_dm2), .demux_out3(q_dm3),
        .delay_start(q_ds), .count_done(q_cd), .rst_flag(q_rf)
    );

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0: return dm0;
            1: return dm1;
            2: return dm2;
            3: return dm3;
            4: return ds;
            5: return cd;
            6: return rf;
            7: return q_ds;
            8: return q_cd;
            default: return 1'b0;
        endcase
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic load(input logic [7:0] a, input logic [12:0] d);
        start = 1'b0;
        i = a;
        instruction = d;
        step();
    endtask

    // Steps until the selected output is seen high; n = cycles taken, -1 if the bound expires.
    task automatic wait_pulse(input int sel, input int limit, output int cycles);
        cycles = -1;
        diff_cycles = 0;
        for (int k = 0; k < 4; k++) pcount[k] = 0;
        for (int t = 1; t <= limit; t++) begin
            step();
            pcount[0] += int'(pwm0);
            pcount[1] += int'(pwm1);
            pcount[2] += int'(pwm2);
            pcount[3] += int'(pwm3);
            if (!(pwm0 == pwm1 && pwm1 == pwm2 && pwm2 == pwm3)) diff_cycles++;
            if (sig(sel)) begin
                cycles = t;
                break;
            end
        end
    endtask

    task automatic expect_pulse(input string tag, input int sel, input int exp_n);
        int got_n;
        wait_pulse(sel, exp_n + 20, got_n);
        check(tag, got_n, exp_n);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        i = 8'd0;
        instruction = 13'd0;
        step();
        step();
        check("reset_outputs", int'({pwm0, pwm1, pwm2, pwm3, dm0, dm1, dm2, dm3, ds, cd, rf}), 0);
        check("reset_outputs_ds4", int'({q_pwm0, q_pwm1, q_pwm2, q_pwm3, q_dm0, q_dm1, q_dm2, q_dm3, q_ds, q_cd, q_rf}), 0);
        rst = 1'b0;

        // Program 1: two-channel on/off sequence with long waits.
        load(8'd1, 13'h0442);
        load(8'd2, 13'h0840);
        load(8'd3, 13'h0440);
        load(8'd4, 13'h0870);
        load(8'd5, 13'h0482);
        load(8'd6, 13'h0840);
        load(8'd7, 13'h0480);
        load(8'd8, 13'h0C00);
        start = 1'b1;
        expect_pulse("t1_demux0_first", 0, 3);
        check("t1_demux_mask", int'({dm3, dm2, dm1, dm0}), 1);
        expect_pulse("t1_delay_start", 4, 2);
        wait_pulse(5, 84, n);
        check("t1_wait64_len", n, 64);
        check("t1_pwm0_duty2", pcount[0], 2);
        check("t1_pwm1_idle", pcount[1], 0);
        expect_pulse("t1_demux0_off", 0, 2);
        check("t1_pwm0_low", int'(pwm0), 0);
        expect_pulse("t1_delay_start2", 4, 2);
        expect_pulse("t1_wait112_len", 5, 112);
        expect_pulse("t1_demux1", 1, 2);
        expect_pulse("t1_delay_start3", 4, 2);
        wait_pulse(5, 84, n);
        check("t1_wait64b_len", n, 64);
        check("t1_pwm1_duty2", pcount[1], 2);
        check("t1_pwm0_off", pcount[0], 0);
        expect_pulse("t1_demux1_off", 1, 2);
        expect_pulse("t1_halt", 6, 2);
        check("t1_halt_pwm", int'({pwm0, pwm1, pwm2, pwm3}), 0);
        step();
        check("t1_halt_stays", int'(rf), 1);

        // Leave HALT, reload and run program 2.
        start = 1'b0;
        i = 8'd0;
        instruction = 13'd0;
        step();
        check("t6_rst_flag_drop", int'(rf), 0);
        load(8'd1, 13'h07E0);
        load(8'd2, 13'h0840);
        load(8'd3, 13'h0800);
        load(8'd4, 13'h053F);
        load(8'd5, 13'h0840);
        load(8'd6, 13'h0C00);
        start = 1'b1;
        expect_pulse("t2_demux0", 0, 3);
        check("t2_demux_all", int'({dm3, dm2, dm1, dm0}), 15);
        expect_pulse("t2_delay_start", 4, 2);
        wait_pulse(5, 84, n);
        check("t2_wait64_len", n, 64);
        check("t2_pwm0_half", pcount[0], 32);
        check("t2_pwm3_half", pcount[3], 32);
        check("t2_in_phase", diff_cycles, 0);
        expect_pulse("t3_delay_start", 4, 2);
        expect_pulse("t3_wait0_done", 5, 1);
        expect_pulse("t3_pc_advance", 2, 2);
        check("t6_only_ch2", int'({dm3, dm2, dm1, dm0}), 4);
        expect_pulse("t6_delay_start", 4, 2);
        wait_pulse(5, 84, n);
        check("t6_wait64_len", n, 64);
        check("t6_pwm2_duty63", pcount[2], 63);
        check("t6_pwm0_kept", pcount[0], 32);
        expect_pulse("t6_halt", 6, 2);

        // DELAY_SCALE=4 instance: WAIT 5 lasts 20 cycles.
        rst = 1'b1;
        step();
        rst = 1'b0;
        load(8'd1, 13'h0805);
        load(8'd2, 13'h0C00);
        start = 1'b1;
        expect_pulse("t4_delay_start", 7, 3);
        expect_pulse("t4_wait5_scale4", 8, 20);

        // Reset in the middle of a WAIT, then rerun from address 1.
        rst = 1'b1;
        step();
        rst = 1'b0;
        load(8'd1, 13'h060A);
        load(8'd2, 13'h0864);
        load(8'd3, 13'h0C00);
        start = 1'b1;
        expect_pulse("t5_demux3", 3, 3);
        expect_pulse("t5_delay_start", 4, 2);
        for (int k = 0; k < 10; k++) step();
        rst = 1'b1;
        step();
        check("t5_reset_outputs", int'({pwm0, pwm1, pwm2, pwm3, dm0, dm1, dm2, dm3, ds, cd, rf}), 0);
        check("t5_reset_outputs_ds4", int'({q_pwm0, q_pwm1, q_pwm2, q_pwm3, q_dm0, q_dm1, q_dm2, q_dm3, q_ds, q_cd, q_rf}), 0);
        rst = 1'b0;
        expect_pulse("t5_rerun_demux3", 3, 3);
        check("t5_rerun_mask", int'({dm3, dm2, dm1, dm0}), 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
